lc3_program_loader: RTL and testbench

//  Byte-stream program loader directly upstream of the LC-3 core. Assembles big-endian bytes from a

---
 rtl/lc3_loader_pkg.sv | 52 +++++
 rtl/lc3_program_loader_if.sv | 24 ++
 rtl/lc3_loader_timeout.sv | 32 +++
 rtl/lc3_program_loader.sv | 150 +++++++++++++++
 tb/tb_lc3_program_loader.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_loader_pkg.sv
// Shared definitions for the LC-3 program loader: FSM encodings, default origin, frame layout.
// LOADER_CHECKSUM_EN selects whether a frame ends with a CSUM word.
package lc3_loader_pkg;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_ORG_LO  = 4'd1;
    localparam logic [3:0] S_LEN_HI  = 4'd2;
    localparam logic [3:0] S_LEN_LO  = 4'd3;
    localparam logic [3:0] S_DAT_HI  = 4'd4;
    localparam logic [3:0] S_DAT_LO  = 4'd5;
    localparam logic [3:0] S_WRITE   = 4'd6;
    localparam logic [3:0] S_CSUM_HI = 4'd7;
    localparam logic [3:0] S_CSUM_LO = 4'd8;
    localparam logic [3:0] S_DONE    = 4'd9;
    localparam logic [3:0] S_ERROR   = 4'd10;

    typedef enum logic [3:0] {
        IDLE    = S_IDLE,
        ORG_LO  = S_ORG_LO,
        LEN_HI  = S_LEN_HI,
        LEN_LO  = S_LEN_LO,
        DAT_HI  = S_DAT_HI,
        DAT_LO  = S_DAT_LO,
        WRITE   = S_WRITE,
        CSUM_HI = S_CSUM_HI,
        CSUM_LO = S_CSUM_LO,
        DONE    = S_DONE,
        ERROR   = S_ERROR
    } state_e;

    localparam logic [15:0] DEFAULT_ORIGIN = 16'h3000;

    // Word order on the wire; every word travels high byte first.
    typedef enum logic [1:0] {FLD_ORIGIN, FLD_LEN, FLD_DATA, FLD_CSUM} frame_field_e;

    // State entered once the last data word has been written (or LEN was zero).
`ifdef LOADER_CHECKSUM_EN
    localparam state_e FRAME_TAIL = CSUM_HI;
`else
    localparam state_e FRAME_TAIL = DONE;
`endif

    function automatic logic [15:0] be_word(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

    // States in which the sender owes us a byte, so inter-byte silence is timed.
    function automatic logic timed_state(input state_e s);
        return s inside {ORG_LO, LEN_HI, LEN_LO, DAT_HI, DAT_LO, CSUM_HI, CSUM_LO};
    endfunction

endpackage

// File: rtl/lc3_program_loader_if.sv
// Byte-receive, memory-write and core-control signals of the program loader.
// master = the loader itself, slave = the receiver/memory/core side.
interface lc3_program_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        cpu_hold;
    logic [15:0] pc_init;
    logic        load_done;
    logic        load_err;

    modport master (
        input  rx_valid, rx_data, mem_ready,
        output rx_ready, mem_we, mem_addr, mem_data, cpu_hold, pc_init, load_done, load_err
    );
    modport slave (
        output rx_valid, rx_data, mem_ready,
        input  rx_ready, mem_we, mem_addr, mem_data, cpu_hold, pc_init, load_done, load_err
    );
endinterface

// File: rtl/lc3_loader_timeout.sv
// Inter-byte idle counter: clears on clr_i, counts while en_i, flags the cycle the limit is hit.
// TIMEOUT_CYCLES = 0 removes the counter and never expires.
module lc3_loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned TMO_W          = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic tmo_unused;
            assign tmo_unused = clk ^ rst_n ^ clr_i ^ en_i;
            assign expire_o   = 1'b0;
        end else begin : g_on
            localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT_CYCLES - 1);
            logic [TMO_W-1:0] cnt_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     cnt_q <= '0;
                else if (clr_i) cnt_q <= '0;
                else if (en_i)  cnt_q <= cnt_q + 1'b1;
            end

            // An accepted byte in the same cycle beats expiry.
            assign expire_o = en_i && !clr_i && (cnt_q == LAST);
        end
    endgenerate
endmodule

// File: rtl/lc3_program_loader.sv
// Byte-stream loader: assembles big-endian words, writes them to LC-3 memory, then releases the core.
// Define LOADER_CHECKSUM_EN for frames carrying a trailing XOR checksum word.
module lc3_program_loader #(
    parameter logic [15:0] DEFAULT_ORIGIN = lc3_loader_pkg::DEFAULT_ORIGIN,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned TMO_W          = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    lc3_program_loader_if.master  bus
);
    import lc3_loader_pkg::*;

    state_e      state_q;
    logic [7:0]  hi_q;
    logic [15:0] org_q, addr_q, rem_q;
    logic        rx_ready_q, mem_we_q, cpu_hold_q, done_q, err_q;
    logic [15:0] mem_addr_q, mem_data_q, pc_init_q;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] csum_q;
`endif

    logic        acc, tmo_en, tmo_exp;
    logic [15:0] word;

    assign acc    = bus.rx_valid && rx_ready_q;
    assign word   = be_word(hi_q, bus.rx_data);
    assign tmo_en = timed_state(state_q);

    lc3_loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TMO_W(TMO_W)) u_tmo (
        .clk(clk), .rst_n(reset), .clr_i(acc), .en_i(tmo_en), .expire_o(tmo_exp)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            org_q      <= '0;
            addr_q     <= '0;
            rem_q      <= '0;
            rx_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            cpu_hold_q <= 1'b1;
            pc_init_q  <= DEFAULT_ORIGIN;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            rx_ready_q <= 1'b1;
            if (tmo_exp) begin
                state_q    <= ERROR;
                err_q      <= 1'b1;
                cpu_hold_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE, DONE, ERROR: if (acc) begin
                        hi_q       <= bus.rx_data;
                        state_q    <= ORG_LO;
                        cpu_hold_q <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                    end
                    ORG_LO: if (acc) begin
                        org_q   <= word;
                        state_q <= LEN_HI;
                    end
                    LEN_HI: if (acc) begin
                        hi_q    <= bus.rx_data;
                        state_q <= LEN_LO;
                    end
                    LEN_LO: if (acc) begin
                        rem_q     <= word;
                        addr_q    <= org_q;
                        pc_init_q <= org_q;
`ifdef LOADER_CHECKSUM_EN
                        csum_q    <= '0;
`endif
                        if (word == 16'h0000) begin
                            state_q    <= FRAME_TAIL;
                            cpu_hold_q <= (FRAME_TAIL != DONE);
                            done_q     <= (FRAME_TAIL == DONE);
                        end else begin
                            state_q <= DAT_HI;
                        end
                    end
                    DAT_HI: if (acc) begin
                        hi_q    <= bus.rx_data;
                        state_q <= DAT_LO;
                    end
                    DAT_LO: if (acc) begin
                        mem_data_q <= word;
                        mem_addr_q <= addr_q;
                        mem_we_q   <= 1'b1;
                        rx_ready_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q     <= csum_q ^ word;
`endif
                        state_q    <= WRITE;
                    end
                    WRITE: begin
                        if (bus.mem_ready) begin
                            mem_we_q <= 1'b0;
                            addr_q   <= addr_q + 16'd1;
                            rem_q    <= rem_q - 16'd1;
                            if (rem_q == 16'd1) begin
                                state_q    <= FRAME_TAIL;
                                cpu_hold_q <= (FRAME_TAIL != DONE);
                                done_q     <= (FRAME_TAIL == DONE);
                            end else begin
                                state_q <= DAT_HI;
                            end
                        end else begin
                            rx_ready_q <= 1'b0;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CSUM_HI: if (acc) begin
                        hi_q    <= bus.rx_data;
                        state_q <= CSUM_LO;
                    end
                    CSUM_LO: if (acc) begin
                        if (word == csum_q) begin
                            state_q    <= DONE;
                            cpu_hold_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end
                    end
`endif
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.pc_init   = pc_init_q;
    assign bus.load_done = done_q;
    assign bus.load_err  = err_q;
endmodule

// File: tb/tb_lc3_program_loader.sv
// Self-checking bench for lc3_program_loader: frame-level model of expected writes and outcome.
module tb_lc3_program_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lc3_program_loader_if bus();
  lc3_program_loader #(.TIMEOUT_CYCLES(10), .TMO_W(17)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  bit rand_ready = 1'b0;
  logic [15:0] words[$];
  logic [31:0] wr_q[$];

  // Memory side: record every accepted write (outputs only change at posedge).
  always @(negedge clk)
    if (bus.mem_we === 1'b1 && bus.mem_ready === 1'b1) wr_q.push_back({bus.mem_addr, bus.mem_data});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      if (rand_ready) bus.mem_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL byte_accept: rx_ready=%b after %0d cycles, required 1", bus.rx_ready, n);
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  // Sends ORIGIN, LEN=words.size(), words (and CSUM) and checks writes and outcome.
  task automatic run_frame(input logic [15:0] org, input bit stall, input bit rnd, input bit bad);
    logic [15:0] cs, len16, ea, tx;
    bit exp_done;
    int len;
    len = words.size();
    len16 = 16'(len);
    cs = 16'h0000;
    foreach (words[i]) cs = cs ^ words[i];
    wr_q.delete();
    rand_ready = rnd;
    bus.mem_ready = 1'b1;
    send_byte(org[15:8]);
    checks++;
    if (bus.load_done !== 1'b0 || bus.load_err !== 1'b0 || bus.cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL restart: done=%b err=%b hold=%b, required 0 0 1", bus.load_done, bus.load_err, bus.cpu_hold);
    end
    send_byte(org[7:0]);
    send_byte(len16[15:8]);
    send_byte(len16[7:0]);
    for (int i = 0; i < len; i++) begin
      ea = org + 16'(i);
      send_byte(words[i][15:8]);
      if (stall && i == 0) begin rand_ready = 1'b0; bus.mem_ready = 1'b0; end
      send_byte(words[i][7:0]);
      checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== ea || bus.mem_data !== words[i] || bus.rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL write_req: we=%b addr=%h data=%h rdy=%b, required 1 %h %h 0",
                 bus.mem_we, bus.mem_addr, bus.mem_data, bus.rx_ready, ea, words[i]);
      end
      if (stall && i == 0) begin
        if (len > 1) begin bus.rx_valid = 1'b1; bus.rx_data = words[1][15:8]; end
        repeat (5) begin
          @(posedge clk); #1;
          checks++;
          if (bus.mem_we !== 1'b1 || bus.mem_addr !== ea || bus.mem_data !== words[0] || bus.rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: we=%b addr=%h data=%h rdy=%b, required 1 %h %h 0",
                     bus.mem_we, bus.mem_addr, bus.mem_data, bus.rx_ready, ea, words[0]);
          end
        end
        bus.mem_ready = 1'b1;
        rand_ready = rnd;
      end
    end
    rand_ready = 1'b0;
    bus.mem_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    tx = bad ? ((cs == 16'h0000) ? 16'h0001 : 16'h0000) : cs;
    exp_done = !bad;
    send_byte(tx[15:8]);
    send_byte(tx[7:0]);
`else
    tx = cs;
    exp_done = 1'b1;
    if (len > 0) begin @(posedge clk); #1; end
`endif
    checks++;
    if (bus.load_done !== exp_done || bus.load_err !== !exp_done || bus.cpu_hold !== !exp_done) begin
      errors++;
      $display("FAIL outcome: done=%b err=%b hold=%b, required %b %b %b (csum %h)",
               bus.load_done, bus.load_err, bus.cpu_hold, exp_done, !exp_done, !exp_done, tx);
    end
    checks++;
    if (bus.pc_init !== org) begin
      errors++;
      $display("FAIL pc_init: got %h, required %h", bus.pc_init, org);
    end
    checks++;
    if (wr_q.size() != len) begin
      errors++;
      $display("FAIL write_count: got %0d, required %0d", wr_q.size(), len);
    end else begin
      foreach (wr_q[i]) begin
        ea = org + 16'(i);
        checks++;
        if (wr_q[i] !== {ea, words[i]}) begin
          errors++;
          $display("FAIL write_%0d: got %h, required %h", i, wr_q[i], {ea, words[i]});
        end
      end
    end
  endtask

  task automatic test_reset;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    bus.mem_ready = 1'b1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.rx_ready !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0 || bus.mem_data !== 16'h0 ||
        bus.cpu_hold !== 1'b1 || bus.pc_init !== 16'h3000 || bus.load_done !== 1'b0 || bus.load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: rdy=%b we=%b a=%h d=%h hold=%b pc=%h done=%b err=%b", bus.rx_ready, bus.mem_we,
               bus.mem_addr, bus.mem_data, bus.cpu_hold, bus.pc_init, bus.load_done, bus.load_err);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.rx_ready !== 1'b1 || bus.cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: rdy=%b hold=%b, required 1 1", bus.rx_ready, bus.cpu_hold);
    end
  endtask

  task automatic test_basic;
    words = '{16'h1234, 16'hABCD};
    run_frame(16'h3000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stall;
    words = '{16'($urandom), 16'($urandom), 16'($urandom)};
    run_frame(16'h4000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_wrap;
    words = '{16'($urandom), 16'($urandom)};
    run_frame(16'hFFFF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_len0;
    words.delete();
    run_frame(16'h5123, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    int n = 0;
    send_byte(8'h30);
    send_byte(8'h00);
    send_byte(8'h00);
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.load_err !== 1'b1 && n < 30);
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL timeout_latency: load_err after %0d cycles, required 10", n);
    end
    checks++;
    if (bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_hold: hold=%b done=%b, required 1 0", bus.cpu_hold, bus.load_done);
    end
    words = '{16'($urandom), 16'($urandom)};
    run_frame(16'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    logic [7:0] bs[7];
    bs = '{8'h30, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    wr_q.delete();
    bus.mem_ready = 1'b1;
    foreach (bs[i]) send_byte(bs[i]);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.rx_ready !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0 || bus.mem_data !== 16'h0 ||
        bus.cpu_hold !== 1'b1 || bus.pc_init !== 16'h3000 || bus.load_done !== 1'b0 || bus.load_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_vals: rdy=%b we=%b a=%h d=%h hold=%b pc=%h done=%b err=%b", bus.rx_ready, bus.mem_we,
               bus.mem_addr, bus.mem_data, bus.cpu_hold, bus.pc_init, bus.load_done, bus.load_err);
    end
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== 32'h3000_1234) begin
      errors++;
      $display("FAIL midreset_mem: %0d writes (first %h), required 1 write 30001234", wr_q.size(),
               (wr_q.size() > 0) ? wr_q[0] : 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.rx_ready !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release: rdy=%b hold=%b done=%b, required 1 1 0", bus.rx_ready, bus.cpu_hold, bus.load_done);
    end
  endtask

  task automatic test_random;
    for (int f = 0; f < 6; f++) begin
      int len;
      len = $urandom_range(1, 5);
      words.delete();
      for (int i = 0; i < len; i++) words.push_back(16'($urandom));
      run_frame(16'($urandom), 1'b0, 1'b1, ($urandom_range(0, 3) == 0));
    end
  endtask

  task automatic test_bad_csum;
    words = '{16'h1234, 16'hABCD};
    run_frame(16'h3000, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_wrap;
    test_len0;
    test_timeout;
    test_reset_mid;
    test_random;
    test_bad_csum;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
